// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO   = 5'd0;

  localparam logic [1:0] STALL_EX   = 2'd2;
  localparam logic [1:0] STALL_MEM  = 2'd1;
  localparam logic [1:0] STALL_LOAD = 2'd1;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX     = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;

  function automatic logic [1:0] max_stall(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// rtl/hazard_ctrl_cmp.sv - one source-operand vs one producer dependency comparator
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_en,
  input  logic [4:0] rd,
  input  logic       valid,
  input  logic       wen,
  output logic       match
);

  // x0 is hard-wired, so a write to it never creates a dependency
  assign match = use_en && valid && wen && (rs == rd) && (rs != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller; HAZARD_FWD_EN adds operand forwarding
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        mem_valid,
  input  logic        mem_wen,
  input  logic [4:0]  mem_rd,
  input  logic        branch_taken,
  output logic        hazard,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  stall_counter,
  output logic [15:0] stall_total
`ifdef HAZARD_FWD_EN
  ,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
`endif
);

  state_t     state, state_nx;
  logic [1:0] cnt_nx;
  logic [1:0] need;
  logic       ex_a, ex_b, mem_a, mem_b;

  hazard_cmp u_cmp_ex_a (
    .rs(id_rs1), .use_en(id_valid && id_use_rs1), .rd(ex_rd),
    .valid(ex_valid), .wen(ex_wen), .match(ex_a)
  );

  hazard_cmp u_cmp_ex_b (
    .rs(id_rs2), .use_en(id_valid && id_use_rs2), .rd(ex_rd),
    .valid(ex_valid), .wen(ex_wen), .match(ex_b)
  );

  hazard_cmp u_cmp_mem_a (
    .rs(id_rs1), .use_en(id_valid && id_use_rs1), .rd(mem_rd),
    .valid(mem_valid), .wen(mem_wen), .match(mem_a)
  );

  hazard_cmp u_cmp_mem_b (
    .rs(id_rs2), .use_en(id_valid && id_use_rs2), .rd(mem_rd),
    .valid(mem_valid), .wen(mem_wen), .match(mem_b)
  );

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load still in EX
  always_comb begin
    need = 2'd0;
    if (ex_is_load && (ex_a || ex_b))
      need = STALL_LOAD;
  end

  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (!reset) begin
      if (ex_a)       fwd_a = FWD_EX;
      else if (mem_a) fwd_a = FWD_MEM;
      if (ex_b)       fwd_b = FWD_EX;
      else if (mem_b) fwd_b = FWD_MEM;
    end
  end
`else
  wire unused_ex_is_load = ex_is_load;

  always_comb begin
    need = 2'd0;
    if (ex_a || ex_b)
      need = max_stall(need, STALL_EX);
    if (mem_a || mem_b)
      need = max_stall(need, STALL_MEM);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      stall_counter <= 2'd0;
    end else begin
      state         <= state_nx;
      stall_counter <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = stall_counter;
    case (state)
      IDLE: begin
        cnt_nx = 2'd0;
        if (branch_taken) begin
          state_nx = FLUSH;
        end else if (need != 2'd0) begin
          cnt_nx   = need - 2'd1;
          state_nx = (need > 2'd1) ? STALL : IDLE;
        end
      end
      STALL: begin
        if (branch_taken) begin
          cnt_nx   = 2'd0;
          state_nx = FLUSH;
        end else begin
          cnt_nx   = stall_counter - 2'd1;
          state_nx = (stall_counter <= 2'd1) ? IDLE : STALL;
        end
      end
      FLUSH: begin
        cnt_nx   = 2'd0;
        state_nx = branch_taken ? FLUSH : IDLE;
      end
      default: begin
        cnt_nx   = 2'd0;
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are forced low during reset so reset wins over branch and stall
  always_comb begin
    hazard      = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (need != 2'd0) begin
            hazard    = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        STALL: begin
          if (branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else begin
            hazard    = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = branch_taken;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_total <= 16'd0;
    else if (hazard && (stall_total != 16'hFFFF))
      stall_total <= stall_total + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a cycle model
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        ex_valid, ex_wen, ex_is_load, mem_valid, mem_wen, branch_taken;
  logic        hazard, bubble_ex, flush_if_id, flush_id_ex;
  logic [1:0]  stall_counter;
  logic [15:0] stall_total;
`ifdef HAZARD_FWD_EN
  logic [1:0]  fwd_a, fwd_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model: stall cycles still owed, pending flush, stalled-cycle tally
  int m_rem   = 0;
  bit m_flush = 0;
  int m_total = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .branch_taken(branch_taken),
    .hazard(hazard), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_counter(stall_counter), .stall_total(stall_total)
`ifdef HAZARD_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ex_hit(input logic [4:0] rs, input logic u);
    return id_valid && u && rs != 0 && ex_valid && ex_wen && ex_rd == rs;
  endfunction

  function automatic bit mem_hit(input logic [4:0] rs, input logic u);
    return id_valid && u && rs != 0 && mem_valid && mem_wen && mem_rd == rs;
  endfunction

  function automatic int model_need();
    int n = 0;
    logic [4:0] rs [2];
    logic       u  [2];
    rs[0] = id_rs1; rs[1] = id_rs2;
    u[0]  = id_use_rs1; u[1] = id_use_rs2;
    for (int i = 0; i < 2; i++) begin
`ifdef HAZARD_FWD_EN
      if (ex_hit(rs[i], u[i]) && ex_is_load) n = 1;
`else
      if (ex_hit(rs[i], u[i]) && n < 2) n = 2;
      if (mem_hit(rs[i], u[i]) && n < 1) n = 1;
`endif
    end
    return n;
  endfunction

  function automatic int model_fwd(input logic [4:0] rs, input logic u);
    if (reset)            return 0;
    if (ex_hit(rs, u))    return 1;
    if (mem_hit(rs, u))   return 2;
    return 0;
  endfunction

  task automatic run_cycle();
    int need, nrem, ntot;
    bit e_haz, e_fif, e_fie, nfl;
    @(negedge clk);
    need  = model_need();
    e_haz = 0; e_fif = 0; e_fie = 0;
    nrem  = 0; nfl = 0;
    if (reset) begin
      nrem = 0;
    end else if (branch_taken) begin
      e_fif = 1; e_fie = 1; nfl = 1;
    end else if (m_flush) begin
      e_fif = 1;
    end else if (m_rem > 0) begin
      e_haz = 1; nrem = m_rem - 1;
    end else if (need > 0) begin
      e_haz = 1; nrem = need - 1;
    end
    ntot = reset ? 0 : ((e_haz && m_total < 65535) ? m_total + 1 : m_total);
    check("hazard", 32'(hazard), 32'(e_haz));
    check("bubble_ex", 32'(bubble_ex), 32'(e_haz));
    check("flush_if_id", 32'(flush_if_id), 32'(e_fif));
    check("flush_id_ex", 32'(flush_id_ex), 32'(e_fie));
    check("stall_counter", 32'(stall_counter), 32'(m_rem));
    check("stall_total", 32'(stall_total), 32'(m_total));
`ifdef HAZARD_FWD_EN
    check("fwd_a", 32'(fwd_a), 32'(model_fwd(id_rs1, id_use_rs1)));
    check("fwd_b", 32'(fwd_b), 32'(model_fwd(id_rs2, id_use_rs2)));
`endif
    @(posedge clk);
    m_rem = nrem; m_flush = nfl; m_total = ntot;
    #1;
  endtask

  task automatic quiet();
    reset = 0; id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
    ex_valid = 0; ex_wen = 0; ex_is_load = 0; mem_valid = 0; mem_wen = 0;
    branch_taken = 0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    run_cycle();
    reset = 0;
  endtask

  task automatic set_ex_dep(input logic [4:0] r, input logic load);
    quiet();
    id_valid = 1; id_use_rs1 = 1; id_rs1 = r;
    ex_valid = 1; ex_wen = 1; ex_rd = r; ex_is_load = load;
  endtask

  initial begin
    quiet();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    run_cycle();
    check("reset_total", 32'(stall_total), 32'd0);
    check("reset_counter", 32'(stall_counter), 32'd0);

    // register 0 never hazards
    set_ex_dep(5'd0, 1'b1);
    repeat (3) run_cycle();
    check("x0_total", 32'(stall_total), 32'd0);

    // EX producer dependency
    do_reset();
    set_ex_dep(5'd5, 1'b0);
    run_cycle();
    quiet();
    repeat (3) run_cycle();
`ifndef HAZARD_FWD_EN
    check("ex_dep_total", 32'(stall_total), 32'd2);
`endif

    // MEM producer dependency
    do_reset();
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 7;
    mem_valid = 1; mem_wen = 1; mem_rd = 7;
    run_cycle();
    quiet();
    repeat (2) run_cycle();

    // branch arriving in the second stall cycle
    do_reset();
    set_ex_dep(5'd9, 1'b1);
    run_cycle();
    branch_taken = 1;
    run_cycle();
    quiet();
    repeat (3) run_cycle();

    // back-to-back branches keep FLUSH
    branch_taken = 1;
    repeat (3) run_cycle();
    quiet();
    repeat (2) run_cycle();

`ifdef HAZARD_FWD_EN
    do_reset();
    set_ex_dep(5'd3, 1'b0);
    #1;
    check("fwd_nonload", 32'(fwd_a), 32'd1);
    check("fwd_nonload_haz", 32'(hazard), 32'd0);
    run_cycle();
    set_ex_dep(5'd3, 1'b1);
    #1;
    check("fwd_load_haz", 32'(hazard), 32'd1);
    run_cycle();
    quiet();
    run_cycle();
`endif

    // reset in the middle of a stall
    do_reset();
    set_ex_dep(5'd4, 1'b1);
    run_cycle();
    quiet();
    reset = 1;
    run_cycle();
    reset = 0;
    run_cycle();
    check("midstall_reset_counter", 32'(stall_counter), 32'd0);
    check("midstall_reset_total", 32'(stall_total), 32'd0);

    // random traffic with a narrow register range to force collisions
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_use_rs1   = $urandom_range(0, 1);
      id_use_rs2   = $urandom_range(0, 1);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_valid     = $urandom_range(0, 1);
      ex_wen       = ($urandom_range(0, 3) != 0);
      ex_is_load   = $urandom_range(0, 1);
      ex_rd        = 5'($urandom_range(0, 3));
      mem_valid    = $urandom_range(0, 1);
      mem_wen      = ($urandom_range(0, 3) != 0);
      mem_rd       = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 11) == 0);
      run_cycle();
    end

    // saturation of the stalled-cycle tally
    do_reset();
    set_ex_dep(5'd12, 1'b1);
    for (int i = 0; i < 65540; i++)
      run_cycle();
    quiet();
    run_cycle();
    check("total_saturated", 32'(stall_total), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
